// File: rtl/slt_unit_pkg.sv
// Shared ALU definitions for the set-less-than result stage.
// Opcode encodings and default result width.
package alu_pkg;

   typedef logic [1:0] alu_op_t;

   localparam alu_op_t ALU_OP_SLT  = 2'b11;
   localparam alu_op_t ALU_OP_SLTU = 2'b10;

   localparam int unsigned SLT_WIDTH_DEF = 32;

endpackage

// File: rtl/slt_unit_if.sv
// Request/result bundle between the adder stage and slt_unit.
// Carries cout only when SLT_UNSIGNED_EN is defined.
interface slt_unit_if #(
   parameter int WIDTH = 32
);

   logic             in_valid;
   logic             a;
   logic             b;
   logic             alu0;
   logic             alu1;
   logic             sumN;
`ifdef SLT_UNSIGNED_EN
   logic             cout;
`endif
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             ovf;

`ifdef SLT_UNSIGNED_EN
   modport master (
      output in_valid, a, b, alu0, alu1, sumN, cout,
      input  out, out_valid, ovf
   );
   modport slave (
      input  in_valid, a, b, alu0, alu1, sumN, cout,
      output out, out_valid, ovf
   );
`else
   modport master (
      output in_valid, a, b, alu0, alu1, sumN,
      input  out, out_valid, ovf
   );
   modport slave (
      input  in_valid, a, b, alu0, alu1, sumN,
      output out, out_valid, ovf
   );
`endif

endinterface

// File: rtl/slt_unit_less_logic.sv
// Combinational less-than / signed-overflow logic from sign bits.
// Unsigned compare output exists only with SLT_UNSIGNED_EN.
module slt_less_logic (
   input  logic a_i,
   input  logic b_i,
   input  logic sumn_i,
`ifdef SLT_UNSIGNED_EN
   input  logic cout_i,
   output logic less_u_o,
`endif
   output logic less_o,
   output logic ovf_o
);

   // Overflow: operand signs differ and result sign differs from A
   assign ovf_o  = (a_i ^ b_i) & (sumn_i ^ a_i);
   assign less_o = sumn_i ^ ovf_o;

`ifdef SLT_UNSIGNED_EN
   assign less_u_o = ~cout_i;
`endif

endmodule

// File: rtl/slt_unit.sv
// Registered SLT result stage: one-cycle latency, zero-extended word.
// SLT_UNSIGNED_EN turns op 2'b10 into SLTU using the adder carry-out.
module slt_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = SLT_WIDTH_DEF
) (
   input logic       clk,
   input logic       rst,
   slt_unit_if.slave bus
);

   alu_op_t op;
   logic    less;
   logic    ovf_c;
   logic    less_d, less_q;
   logic    ovf_d, ovf_q;
   logic    valid_q;

`ifdef SLT_UNSIGNED_EN
   logic    less_u;
`endif

   assign op = {bus.alu1, bus.alu0};

   slt_less_logic u_less (
      .a_i      (bus.a),
      .b_i      (bus.b),
      .sumn_i   (bus.sumN),
`ifdef SLT_UNSIGNED_EN
      .cout_i   (bus.cout),
      .less_u_o (less_u),
`endif
      .less_o   (less),
      .ovf_o    (ovf_c)
   );

   always_comb begin
      less_d = less_q;
      ovf_d  = ovf_q;
      if (bus.in_valid) begin
         less_d = 1'b0;
         ovf_d  = 1'b0;
         unique case (1'b1)
            (op == ALU_OP_SLT): begin
               less_d = less;
               ovf_d  = ovf_c;
            end
`ifdef SLT_UNSIGNED_EN
            (op == ALU_OP_SLTU): begin
               less_d = less_u;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         less_q  <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         less_q  <= less_d;
         ovf_q   <= ovf_d;
         valid_q <= bus.in_valid;
      end
   end

   assign bus.out       = {{(WIDTH-1){1'b0}}, less_q};
   assign bus.ovf       = ovf_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_slt_unit.sv
// Scoreboard bench for slt_unit: operands modelled as full 32-bit values.
// Build with SLT_UNSIGNED_EN to exercise the SLTU path.
module tb_slt_unit;

   localparam int W = 32;

   typedef struct {
      bit          v;
      logic [31:0] o;
      bit          f;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t q[$];
   logic [31:0] m_out;
   bit          m_ovf;

   slt_unit_if #(.WIDTH(W)) bus ();

   slt_unit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input bit r, input bit v, input logic [1:0] op,
                       input logic [31:0] ra, input logic [31:0] rb);
      logic [31:0] diff;
      longint      sd;
      bit          slt, sovf, sltu;
      exp_t        e;
      @(negedge clk);
      diff = ra - rb;
      rst          = r;
      bus.in_valid = v;
      bus.a        = ra[31];
      bus.b        = rb[31];
      bus.sumN     = diff[31];
      bus.alu1     = op[1];
      bus.alu0     = op[0];
`ifdef SLT_UNSIGNED_EN
      bus.cout     = (ra >= rb);
`endif
      sd   = longint'($signed(ra)) - longint'($signed(rb));
      sovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      slt  = $signed(ra) < $signed(rb);
      sltu = ra < rb;
      if (r) begin
         m_out = '0;
         m_ovf = 1'b0;
      end else if (v) begin
         m_out = '0;
         m_ovf = 1'b0;
         if (op == 2'b11) begin
            m_out = {31'b0, slt};
            m_ovf = sovf;
         end
`ifdef SLT_UNSIGNED_EN
         if (op == 2'b10) m_out = {31'b0, sltu};
`endif
      end
      e.v = v && !r;
      e.o = m_out;
      e.f = m_ovf;
      q.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.out_valid !== e.v) begin
               errors++;
               $display("FAIL out_valid got %b want %b t=%0t",
                        bus.out_valid, e.v, $time);
            end
            checks++;
            if (bus.out !== e.o) begin
               errors++;
               $display("FAIL out got %h want %h t=%0t",
                        bus.out, e.o, $time);
            end
            checks++;
            if (bus.ovf !== e.f) begin
               errors++;
               $display("FAIL ovf got %b want %b t=%0t",
                        bus.ovf, e.f, $time);
            end
         end
      end
   end

   initial begin
      logic [1:0] op;
      checks = 0;
      errors = 0;
      m_out  = '0;
      m_ovf  = 1'b0;
      rst    = 1'b1;
      bus.in_valid = 1'b0;
      bus.a = 1'b0; bus.b = 1'b0; bus.sumN = 1'b0;
      bus.alu0 = 1'b0; bus.alu1 = 1'b0;
`ifdef SLT_UNSIGNED_EN
      bus.cout = 1'b0;
`endif
      // reset dominates a valid SLT request
      step(1, 1, 2'b11, 32'h8000_0000, 32'h1);
      step(1, 1, 2'b11, 32'h8000_0000, 32'h1);
      step(0, 1, 2'b11, 32'h8000_0000, 32'h1);
      // non-SLT op sweep of sign pairs, sumN = 0
      step(0, 1, 2'b00, 32'd5, 32'd3);
      step(0, 1, 2'b00, 32'd0, 32'hFFFF_FFFF);
      step(0, 1, 2'b00, 32'h8000_0000, 32'd1);
      step(0, 1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      // SLT with and without overflow
      step(0, 1, 2'b11, 32'd1, 32'd2);
      step(0, 1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      step(0, 1, 2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
      step(0, 1, 2'b11, 32'h8000_0000, 32'd1);
      step(0, 1, 2'b11, 32'd1, 32'd2);
      // hold with in_valid low
      for (int i = 0; i < 3; i++)
         step(0, 0, 2'($urandom), $urandom, $urandom);
      // op 10: SLTU when enabled, plain zero otherwise
      step(0, 1, 2'b10, 32'd1, 32'd2);
      step(0, 1, 2'b10, 32'd2, 32'd1);
      step(0, 1, 2'b10, 32'hFFFF_FFFF, 32'd0);
      step(0, 1, 2'b01, 32'd1, 32'd2);
      // mid-stream reset
      step(0, 1, 2'b11, 32'd1, 32'd2);
      step(1, 1, 2'b11, 32'd1, 32'd2);
      step(0, 0, 2'b11, 32'd1, 32'd2);
      for (int i = 0; i < 400; i++) begin
         op = 2'($urandom);
         if ($urandom_range(3) == 0)
            step(($urandom_range(39) == 0), ($urandom_range(3) != 0), op,
                 {$urandom_range(1), 31'($urandom_range(3))},
                 {$urandom_range(1), 31'($urandom_range(3))});
         else
            step(($urandom_range(39) == 0), ($urandom_range(3) != 0), op,
                 $urandom, $urandom);
      end
      step(0, 0, 2'b00, 32'd0, 32'd0);
      repeat (3) @(posedge clk);
      #5;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
